fetch_sequencer: RTL and testbench

Program-counter sequencer for the instruction ROM. It owns the PC and drives the ROM address, qualifies the returned word as a valid instruction, and applies stall, branch and halt requests from the decode/control stage. It implements the top-level start/done handshake: a start pulse launches the program at address 0, and done is raised when the program halts or runs off the end of ROM. It sits between the top level and the ROM, feeding instructions to decode.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_next_pc.sv | 32 +++
 rtl/fetch_sequencer.sv | 102 ++++++++++
 tb/tb_fetch_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer.
// State encoding, default widths and the address type.
package fetch_pkg;

  localparam int unsigned A_DEF  = 10;
  localparam int unsigned W_DEF  = 9;
  localparam int unsigned CW_DEF = 16;

  typedef logic [A_DEF-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for one RUN cycle: stall > halt > branch > increment.
// Ports: pc_i, stall_i, halt_i, branch_*_i in; pc_nxt_o, rom_end_o out.
module fetch_next_pc #(
  parameter int A = 10
) (
  input  logic [A-1:0] pc_i,
  input  logic         stall_i,
  input  logic         halt_i,
  input  logic         branch_en_i,
  input  logic         branch_rel_i,
  input  logic [A-1:0] branch_target_i,
  output logic [A-1:0] pc_nxt_o,
  output logic         rom_end_o
);

  always_comb begin
    pc_nxt_o  = pc_i;
    rom_end_o = 1'b0;
    if (stall_i || halt_i) begin
      pc_nxt_o = pc_i;
    end else if (branch_en_i) begin
      // Offset is already A bits, so plain A-bit add gives sext + wrap.
      pc_nxt_o = branch_rel_i ? pc_i + branch_target_i
                              : branch_target_i;
    end else if (pc_i == '1) begin
      rom_end_o = 1'b1;
    end else begin
      pc_nxt_o = pc_i + A'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer for the instruction ROM with start/done handshake.
// Ports: clk, reset, start, stall, halt, branch_* in; inst_*, busy, done, overrun, retired out.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int A  = A_DEF,
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          halt,
  input  logic          branch_en,
  input  logic          branch_rel,
  input  logic [A-1:0]  branch_target,
  output logic [A-1:0]  inst_addr,
  input  logic [W-1:0]  inst_in,
  output logic [W-1:0]  inst_out,
  output logic          inst_valid,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic [CW-1:0] retired
);

  fetch_state_t  state_q, state_d;
  logic [A-1:0]  pc_q, pc_d, pc_nxt;
  logic [CW-1:0] retired_q, retired_d;
  logic          overrun_q, overrun_d;
  logic          rom_end;
  logic          launch;
  logic          retire;

  fetch_next_pc #(.A(A)) u_next_pc (
    .pc_i            (pc_q),
    .stall_i         (stall),
    .halt_i          (halt),
    .branch_en_i     (branch_en),
    .branch_rel_i    (branch_rel),
    .branch_target_i (branch_target),
    .pc_nxt_o        (pc_nxt),
    .rom_end_o       (rom_end)
  );

  assign launch = (state_q != RUN) && start;
  assign retire = (state_q == RUN) && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      retired_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!stall && (halt || rom_end)) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    overrun_d = overrun_q;
    if (launch) begin
      pc_d      = '0;
      retired_d = '0;
      overrun_d = 1'b0;
    end else if (state_q == RUN) begin
      pc_d = pc_nxt;
      if (retire && retired_q != '1) begin
        retired_d = retired_q + CW'(1);
      end
      if (rom_end) overrun_d = 1'b1;
    end
  end

  always_comb begin
    busy       = (state_q == RUN);
    done       = (state_q == DONE);
    inst_valid = (state_q == RUN) && !stall;
  end

  assign inst_addr = pc_q;
  assign inst_out  = inst_in;
  assign overrun   = overrun_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer (A=10 and A=4 instances).
// Table-driven RUN sequences plus hand-written reset and overrun cases.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, stall, halt, branch_en, branch_rel;
  logic [9:0] branch_target, inst_addr;
  logic [8:0] inst_in, inst_out;
  logic       inst_valid, busy, done, overrun;
  logic [15:0] retired;

  logic       rst4, start4;
  logic [3:0] addr4;
  logic [8:0] in4, out4;
  logic       valid4, busy4, done4, ovr4;
  logic [15:0] ret4;

  assign inst_in = inst_addr[8:0] ^ 9'h0A5;
  assign in4     = {5'd0, addr4} ^ 9'h1C3;

  fetch_sequencer #(.A(10), .W(9), .CW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .halt(halt), .branch_en(branch_en), .branch_rel(branch_rel),
    .branch_target(branch_target), .inst_addr(inst_addr),
    .inst_in(inst_in), .inst_out(inst_out), .inst_valid(inst_valid),
    .busy(busy), .done(done), .overrun(overrun), .retired(retired)
  );

  fetch_sequencer #(.A(4), .W(9), .CW(16)) dut4 (
    .clk(clk), .reset(rst4), .start(start4), .stall(1'b0),
    .halt(1'b0), .branch_en(1'b0), .branch_rel(1'b0),
    .branch_target(4'd0), .inst_addr(addr4),
    .inst_in(in4), .inst_out(out4), .inst_valid(valid4),
    .busy(busy4), .done(done4), .overrun(ovr4), .retired(ret4)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic st, sl, hl, be, br;
    logic [9:0] tg;
    logic [9:0] ea;
    logic ev, eb, ed, eo;
    logic [15:0] er;
  } vec_t;

  function automatic vec_t mk(
    input logic st, sl, hl, be, br,
    input logic [9:0] tg, ea,
    input logic ev, eb, ed, eo,
    input logic [15:0] er);
    vec_t v;
    v.st = st; v.sl = sl; v.hl = hl; v.be = be; v.br = br;
    v.tg = tg; v.ea = ea;
    v.ev = ev; v.eb = eb; v.ed = ed; v.eo = eo; v.er = er;
    return v;
  endfunction

  vec_t tv[23];

  initial begin
    // st sl hl be br tg | addr valid busy done ovr ret
    tv[0]  = mk(1,0,0,0,0,10'h0,   10'h0,   0,0,0,0, 0);
    tv[1]  = mk(0,0,0,0,0,10'h0,   10'h0,   1,1,0,0, 0);
    tv[2]  = mk(0,0,0,0,0,10'h0,   10'h1,   1,1,0,0, 1);
    tv[3]  = mk(0,0,0,0,0,10'h0,   10'h2,   1,1,0,0, 2);
    tv[4]  = mk(0,0,0,0,0,10'h0,   10'h3,   1,1,0,0, 3);
    tv[5]  = mk(0,0,0,0,0,10'h0,   10'h4,   1,1,0,0, 4);
    tv[6]  = mk(0,0,1,0,0,10'h0,   10'h5,   1,1,0,0, 5);
    tv[7]  = mk(0,0,0,0,0,10'h0,   10'h5,   0,0,1,0, 6);
    tv[8]  = mk(1,0,0,0,0,10'h0,   10'h5,   0,0,1,0, 6);
    tv[9]  = mk(0,0,0,0,0,10'h0,   10'h0,   1,1,0,0, 0);
    tv[10] = mk(0,0,0,0,0,10'h0,   10'h1,   1,1,0,0, 1);
    tv[11] = mk(0,0,0,0,0,10'h0,   10'h2,   1,1,0,0, 2);
    tv[12] = mk(0,0,0,1,0,10'h100, 10'h3,   1,1,0,0, 3);
    tv[13] = mk(0,0,0,1,1,10'h3FE, 10'h100, 1,1,0,0, 4);
    tv[14] = mk(0,0,0,1,0,10'h7,   10'h0FE, 1,1,0,0, 5);
    tv[15] = mk(0,1,1,1,0,10'h0,   10'h7,   0,1,0,0, 6);
    tv[16] = mk(0,1,1,1,0,10'h0,   10'h7,   0,1,0,0, 6);
    tv[17] = mk(0,1,1,1,0,10'h0,   10'h7,   0,1,0,0, 6);
    tv[18] = mk(0,0,0,0,0,10'h0,   10'h7,   1,1,0,0, 6);
    tv[19] = mk(0,0,0,1,0,10'h3FF, 10'h8,   1,1,0,0, 7);
    tv[20] = mk(0,0,0,1,1,10'h2,   10'h3FF, 1,1,0,0, 8);
    tv[21] = mk(0,0,1,0,0,10'h0,   10'h1,   1,1,0,0, 9);
    tv[22] = mk(0,0,0,0,0,10'h0,   10'h1,   0,0,1,0, 10);

    reset = 1'b1; start = 1'b0; stall = 1'b0; halt = 1'b0;
    branch_en = 1'b0; branch_rel = 1'b0; branch_target = '0;
    rst4 = 1'b1; start4 = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst.addr",  32'(inst_addr), 32'h0);
    chk("rst.busy",  32'(busy), 32'h0);
    chk("rst.done",  32'(done), 32'h0);
    chk("rst.valid", 32'(inst_valid), 32'h0);
    chk("rst.ret",   32'(retired), 32'h0);
    chk("rst.ovr",   32'(overrun), 32'h0);
    chk("rst.inst",  32'(inst_out), 32'(9'h0A5));
    reset = 1'b0;
    rst4  = 1'b0;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      start = tv[i].st; stall = tv[i].sl; halt = tv[i].hl;
      branch_en = tv[i].be; branch_rel = tv[i].br;
      branch_target = tv[i].tg;
      #1;
      chk($sformatf("v%0d.addr", i),  32'(inst_addr), 32'(tv[i].ea));
      chk($sformatf("v%0d.valid", i), 32'(inst_valid), 32'(tv[i].ev));
      chk($sformatf("v%0d.busy", i),  32'(busy), 32'(tv[i].eb));
      chk($sformatf("v%0d.done", i),  32'(done), 32'(tv[i].ed));
      chk($sformatf("v%0d.ovr", i),   32'(overrun), 32'(tv[i].eo));
      chk($sformatf("v%0d.ret", i),   32'(retired), 32'(tv[i].er));
      chk($sformatf("v%0d.inst", i),  32'(inst_out),
          32'(tv[i].ea[8:0] ^ 9'h0A5));
    end

    // Relaunch, run to PC=9, then async reset mid-cycle.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("ar.pc9", 32'(inst_addr), 32'h9);
    chk("ar.ret9", 32'(retired), 32'h9);
    #2;
    reset = 1'b1; start = 1'b1;
    #1;
    chk("ar.addr",  32'(inst_addr), 32'h0);
    chk("ar.busy",  32'(busy), 32'h0);
    chk("ar.valid", 32'(inst_valid), 32'h0);
    chk("ar.ret",   32'(retired), 32'h0);
    @(posedge clk); #1;
    chk("ar.hold.busy", 32'(busy), 32'h0);
    chk("ar.hold.done", 32'(done), 32'h0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    chk("ar.launch.busy", 32'(busy), 32'h1);
    chk("ar.launch.addr", 32'(inst_addr), 32'h0);
    chk("ar.launch.ret",  32'(retired), 32'h0);
    start = 1'b0;

    // A=4 instance: run off the end of ROM.
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      chk($sformatf("ov.pc%0d", i), 32'(addr4), 32'(i));
      chk($sformatf("ov.valid%0d", i), 32'(valid4), 32'h1);
    end
    @(negedge clk); #1;
    chk("ov.done", 32'(done4), 32'h1);
    chk("ov.busy", 32'(busy4), 32'h0);
    chk("ov.ovr",  32'(ovr4), 32'h1);
    chk("ov.ret",  32'(ret4), 32'd16);
    chk("ov.pc",   32'(addr4), 32'hF);
    chk("ov.inst", 32'(out4), 32'(9'h1CC));
    start4 = 1'b1;
    @(negedge clk); #1;
    start4 = 1'b0;
    chk("ov.re.busy", 32'(busy4), 32'h1);
    chk("ov.re.pc",   32'(addr4), 32'h0);
    chk("ov.re.ovr",  32'(ovr4), 32'h0);
    chk("ov.re.ret",  32'(ret4), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
